// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake bundle for one pipeline stage boundary (upstream
//               push side, downstream pop side, flush and occupancy).
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 111,
    parameter int CTRL_W = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    // Surrounding pipeline / bench side: drives entries in, accepts them out.
    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    // Stage register side.
    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic valid/ready pipeline stage register with flush and
//               bubble-to-NOP on the control field. Define PIPE_STAGE_SKID_EN
//               for a two-entry skid build with a registered in_ready.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W   = 111,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pipe_stage_reg_if.slave bus
);

    logic              w_push;
    logic              w_pop;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = r_main_valid & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [1:0]        r_occupancy;
    logic [1:0]        w_occupancy_nxt;

    // Ready depends only on the skid flop, so out_ready never reaches in_ready.
    assign bus.in_ready = ~r_skid_valid;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        if (bus.flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = CTRL_NOP;
            w_skid_valid_nxt = 1'b0;
            w_skid_ctrl_nxt  = CTRL_NOP;
        end else if (r_skid_valid) begin
            // in_ready is low here, so the only possible event is a pop.
            if (w_pop) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_main_ctrl_nxt  = r_skid_ctrl;
                w_skid_valid_nxt = 1'b0;
                w_skid_ctrl_nxt  = CTRL_NOP;
            end
        end else if (w_push) begin
            if (!r_main_valid || w_pop) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = bus.in_data;
                w_main_ctrl_nxt  = bus.in_ctrl;
            end else begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = bus.in_data;
                w_skid_ctrl_nxt  = bus.in_ctrl;
            end
        end else if (w_pop) begin
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = CTRL_NOP;
        end
    end

    assign w_occupancy_nxt = {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= CTRL_NOP;
            r_occupancy  <= 2'd0;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_occupancy  <= w_occupancy_nxt;
        end
    end

    assign bus.occupancy = r_occupancy;
`else
    // Single entry: accept whenever the held entry is absent or leaving now.
    assign bus.in_ready = ~r_main_valid | bus.out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        if (bus.flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = CTRL_NOP;
        end else if (w_push) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = bus.in_data;
            w_main_ctrl_nxt  = bus.in_ctrl;
        end else if (w_pop) begin
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = CTRL_NOP;
        end
    end

    assign bus.occupancy = {1'b0, r_main_valid};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= CTRL_NOP;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
        end
    end

    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_ctrl  = r_main_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg with an
//               in-order scoreboard; honours PIPE_STAGE_SKID_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DATA_W = 111;
    localparam int          CTRL_W = 8;
    localparam logic [7:0]  C_NOP  = 8'h00;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP    = 2;
`else
    localparam int          CAP    = 1;
`endif

    logic clk;
    logic rst_n;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_NOP(C_NOP)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pops the scoreboard for an entry leaving at the coming edge, then
    // advances to 1 time unit after that edge.
    task automatic tick();
        logic [DATA_W-1:0] ed;
        logic [CTRL_W-1:0] ec;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q_data.size() == 0) begin
                chk("sb_underflow", 128'(q_data.size()), 128'd1);
            end else begin
                ed = q_data.pop_front();
                ec = q_ctrl.pop_front();
                chk("sb_data", 128'(bus.out_data), 128'(ed));
                chk("sb_ctrl", 128'(bus.out_ctrl), 128'(ec));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = r;
        #1;
    endtask

    task automatic expect_push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        q_data.push_back(d);
        q_ctrl.push_back(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, '0, C_NOP, 1'b0);

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data",  128'(bus.out_data),  128'd0);
        chk("rst_out_ctrl",  128'(bus.out_ctrl),  128'(C_NOP));
        chk("rst_occupancy", 128'(bus.occupancy), 128'd0);
        chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
        rst_n = 1'b1;

        // Stream 0..9 at full rate
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DATA_W'(i), 8'h41, 1'b1);
            chk("stream_in_ready", 128'(bus.in_ready), 128'd1);
            expect_push(DATA_W'(i), 8'h41);
            tick();
            chk("stream_out_valid", 128'(bus.out_valid), 128'd1);
            chk("stream_out_data",  128'(bus.out_data),  128'(i));
        end

        // Bubble after the last pop
        drive(1'b0, '0, C_NOP, 1'b1);
        tick();
        chk("bubble_out_valid", 128'(bus.out_valid), 128'd0);
        chk("bubble_out_ctrl",  128'(bus.out_ctrl),  128'(C_NOP));
        chk("bubble_out_data",  128'(bus.out_data),  128'd9);
        chk("bubble_occupancy", 128'(bus.occupancy), 128'd0);
        chk("bubble_sb_empty",  128'(q_data.size()), 128'd0);

`ifdef PIPE_STAGE_SKID_EN
        // Back-pressure: A to main, B to skid, C held upstream
        drive(1'b1, DATA_W'(5), 8'h41, 1'b0);
        chk("bp_a_ready", 128'(bus.in_ready), 128'd1);
        expect_push(DATA_W'(5), 8'h41);
        tick();
        drive(1'b1, DATA_W'(6), 8'h41, 1'b0);
        chk("bp_b_ready", 128'(bus.in_ready), 128'd1);
        expect_push(DATA_W'(6), 8'h41);
        tick();
        drive(1'b1, DATA_W'(7), 8'h41, 1'b0);
        chk("bp_full_ready", 128'(bus.in_ready),  128'd0);
        chk("bp_full_occ",   128'(bus.occupancy), 128'd2);
        tick();
        chk("bp_hold_occ",   128'(bus.occupancy), 128'd2);
        chk("bp_hold_data",  128'(bus.out_data),  128'd5);
        chk("bp_hold_ready", 128'(bus.in_ready),  128'd0);
        drive(1'b1, DATA_W'(7), 8'h41, 1'b1);
        tick();
        chk("bp_drain_ready", 128'(bus.in_ready),  128'd1);
        chk("bp_drain_occ",   128'(bus.occupancy), 128'd1);
        chk("bp_drain_data",  128'(bus.out_data),  128'd6);
        expect_push(DATA_W'(7), 8'h41);
        tick();
        drive(1'b0, '0, C_NOP, 1'b1);
        chk("bp_c_data", 128'(bus.out_data), 128'd7);
        tick();
        chk("bp_end_valid", 128'(bus.out_valid), 128'd0);
`else
        // Combinational ready without skid storage
        drive(1'b1, DATA_W'('h77), 8'h41, 1'b0);
        expect_push(DATA_W'('h77), 8'h41);
        tick();
        drive(1'b1, DATA_W'('h78), 8'h41, 1'b0);
        chk("noskid_stall_ready", 128'(bus.in_ready), 128'd0);
        tick();
        chk("noskid_hold_data", 128'(bus.out_data),  128'h77);
        chk("noskid_hold_occ",  128'(bus.occupancy), 128'd1);
        drive(1'b1, DATA_W'('h78), 8'h41, 1'b1);
        chk("noskid_comb_ready", 128'(bus.in_ready), 128'd1);
        expect_push(DATA_W'('h78), 8'h41);
        tick();
        chk("noskid_popush_valid", 128'(bus.out_valid), 128'd1);
        chk("noskid_popush_data",  128'(bus.out_data),  128'h78);
        drive(1'b0, '0, C_NOP, 1'b1);
        tick();
        chk("noskid_end_valid", 128'(bus.out_valid), 128'd0);
`endif

        // Flush a full stage with a push in the same cycle
        for (int i = 0; i < CAP; i++) begin
            drive(1'b1, DATA_W'('h11 + i), 8'hFF, 1'b0);
            tick();
        end
        chk("flush_pre_occ", 128'(bus.occupancy), 128'(CAP));
        bus.flush = 1'b1;
        drive(1'b1, DATA_W'(9), 8'hFF, 1'b0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, '0, C_NOP, 1'b1);
        chk("flush_out_valid", 128'(bus.out_valid), 128'd0);
        chk("flush_out_ctrl",  128'(bus.out_ctrl),  128'(C_NOP));
        chk("flush_occupancy", 128'(bus.occupancy), 128'd0);
        chk("flush_out_data",  128'(bus.out_data),  128'h11);
        chk("flush_in_ready",  128'(bus.in_ready),  128'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_ghost", 128'(bus.out_valid), 128'd0);
        end

        // Asynchronous reset between edges with the stage full
        for (int i = 0; i < CAP; i++) begin
            drive(1'b1, DATA_W'('h21 + i), 8'h41, 1'b0);
            tick();
        end
        chk("arst_pre_occ", 128'(bus.occupancy), 128'(CAP));
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("arst_occupancy", 128'(bus.occupancy), 128'd0);
        chk("arst_out_ctrl",  128'(bus.out_ctrl),  128'(C_NOP));
        chk("arst_out_data",  128'(bus.out_data),  128'd0);
        rst_n = 1'b1;

        // First push right after release
        drive(1'b1, DATA_W'('h55), 8'h41, 1'b0);
        expect_push(DATA_W'('h55), 8'h41);
        tick();
        chk("arst_first_valid", 128'(bus.out_valid), 128'd1);
        drive(1'b0, '0, C_NOP, 1'b1);
        tick();
        chk("final_out_valid", 128'(bus.out_valid), 128'd0);
        chk("final_sb_empty",  128'(q_data.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic successor of the fixed-field inter-stage latches, and any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it. Payload is split into a data field and a control field: a flush or a bubble turns the control field into a NOP, while the data field holds its value. Back-pressure lets a stalled downstream stage stop the upstream stage without losing instructions.

## Interface
Parameters:
- DATA_W, default 111: data payload width (operands, immediate, register ids).
- CTRL_W, default 8: control payload width (ALU op, RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite).
- CTRL_NOP, default {CTRL_W{1'b0}}: control value for an empty stage; used at reset, flush and bubble.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of every held entry.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents an entry downstream.
- out_ready  in  1  downstream accepts the presented entry.
- out_data  out  DATA_W  presented data payload.
- out_ctrl  out  CTRL_W  presented control payload; equals CTRL_NOP whenever out_valid=0.
- occupancy  out  2  number of held entries (0..2; 0..1 without skid).

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Main entry drives the out_* ports. With the skid buffer enabled, the skid entry holds one overflow entry.
- Skid mode: in_ready = !skid_valid, driven straight from a flop with no combinational path from out_ready.
  - Main empty, push: the entry goes to main.
  - Main full, pop and push: the entry goes to main.
  - Main full, no pop, push: the entry goes to skid.
  - Pop with skid full: skid moves to main and skid becomes empty. No push can happen because in_ready=0.
- When main goes empty (pop with no push and no skid), out_valid drops to 0, out_ctrl is loaded with CTRL_NOP, and out_data holds its value.
- Flush has priority over every other event.
  - Both valids clear, and the main and skid control fields load CTRL_NOP. Data fields hold.
  - A push in the flush cycle is discarded. Upstream must kill its own in-flight entry on flush.
  - A pop in the flush cycle completes, because downstream has already sampled it.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (asynchronous, rst_n=0), every output forced immediately:
  - out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0.
  - in_ready=1; the skid entry is also cleared.
- Latency: an entry accepted at edge N appears on out_* after edge N, so one cycle.
- Throughput: one entry per cycle with out_ready held high, in both modes.
- Skid mode: in_ready falls the cycle after the skid fills. It rises the cycle after a pop drains the skid.
- Skid-off mode: in_ready = !out_valid | out_ready. This is combinational from out_ready.
- Flush at edge N: at N+1, out_valid=0, out_ctrl=CTRL_NOP, occupancy=0 and in_ready=1.
- rst_n deasserted mid-transfer: no entry survives. The first push is accepted at the first rising edge with rst_n=1.
- out_* and occupancy are registered. Only in_ready is combinational, and only in skid-off mode.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry storage with in_ready registered. This breaks the ready timing path across stages; occupancy reaches 2.
- PIPE_STAGE_SKID_EN undefined: a single entry with no skid flops. in_ready is combinational as given above, and occupancy[1] is tied to 0.
- Handshake, flush and bubble semantics are the same in both builds.

## Test plan
- Reset then stream: rst_n low for 3 cycles, then in_valid=1 with in_data=0..9, in_ctrl=8'h41 and out_ready=1. Required: out_valid rises one cycle after each push, and out_data is 0..9 in order with no gaps.
- Back-pressure (skid on): push A=5, B=6 and C=7 with out_ready=0. Required: A in main, B in skid, occupancy=2 and in_ready=0, with C held upstream. Then raise out_ready: pops A, then B, then C, with in_ready=1 again one cycle after the skid drains.
- Flush with full stage: occupancy=2 and ctrl=8'hFF, then pulse flush with in_valid=1 and in_data=9. Required next cycle: out_valid=0, out_ctrl=8'h00, occupancy=0, out_data unchanged, and 9 never appears at the output.
- Bubble: push one entry with ctrl=8'h41, pop it, then idle. Required: out_valid=0 and out_ctrl=8'h00 on the following cycle, with out_data still holding the last value.
- Async reset mid-stream: assert rst_n=0 between edges while occupancy=2. Required: out_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
- Skid-off build: out_ready=0 with out_valid=1. Required: in_ready=0 in the same cycle. Then out_ready=1 with in_valid=1: in_ready=1 combinationally, and a simultaneous pop and push keeps out_valid=1.
